// File: rtl/inst_sram_resp.sv
// Instruction-side SRAM responder: one request per cycle, 1-cycle read latency, byte-lane writes.
// After reset it optionally zero-fills the array before it serves requests.
module inst_sram_resp #(
  parameter logic [31:0] ADDR_BASE   = 32'h1C00_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter bit          INIT_CLEAR  = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  output logic        inst_sram_err,
  output logic        init_done
);

  localparam int unsigned       IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [31:0]       WIN_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH_WORDS - 1);

  typedef enum logic [1:0] {ST_RESET, ST_CLEAR, ST_READY} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic [31:0]      mem [DEPTH_WORDS];
  logic             mem_we;
  logic [IDX_W-1:0] mem_idx;
  logic [3:0]       mem_be;
  logic [31:0]      mem_wdata;

  logic [31:0]      off;
  logic             hit;
  logic [IDX_W-1:0] req_idx;
  logic             clearing;
  logic             unused_bits;

  // The offset wraps in 32 bits, so addresses below the base become large misses.
  assign off         = {inst_sram_addr[31:2], 2'b00} - ADDR_BASE;
  assign hit         = off < WIN_BYTES;
  assign req_idx     = off[IDX_W+1:2];
  assign unused_bits = ^{inst_sram_addr[1:0], off[31:IDX_W+2]};

  // The first edge after reset release already does the work of the following state.
  assign clearing = (state_q == ST_CLEAR) || ((state_q == ST_RESET) && INIT_CLEAR);

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_idx   = req_idx;
    mem_be    = 4'h0;
    mem_wdata = inst_sram_wdata;
    if (clearing) begin
      state_d   = ST_CLEAR;
      mem_we    = 1'b1;
      mem_idx   = clr_idx_q;
      mem_be    = 4'hF;
      mem_wdata = 32'h0;
      clr_idx_d = clr_idx_q + IDX_W'(1);
      if (clr_idx_q == LAST_IDX) begin
        state_d = ST_READY;
      end
    end else begin
      state_d = ST_READY;
      if (inst_sram_en) begin
        if (hit) begin
          rdata_d = mem[req_idx];
          err_d   = 1'b0;
          mem_we  = 1'b1;
          mem_be  = inst_sram_wen;
        end else begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_RESET;
      clr_idx_q <= '0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_be[i]) begin
          mem[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
      end
    end
  end

  assign inst_sram_rdata = rdata_q;
  assign inst_sram_err   = err_q;
  assign init_done       = (state_q == ST_READY);

endmodule

// File: tb/tb_inst_sram_resp.sv
// Bench for inst_sram_resp: directed scenarios plus random traffic checked against
// a word-array reference model of the address window.
module tb_inst_sram_resp;

  localparam logic [31:0] BASE  = 32'h1C00_0000;
  localparam int          DEPTH = 16;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  wen = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        err;
  logic        init_done;

  always #5 clk = ~clk;

  inst_sram_resp #(
    .ADDR_BASE  (BASE),
    .DEPTH_WORDS(DEPTH),
    .INIT_CLEAR (1'b1)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .inst_sram_en   (en),
    .inst_sram_wen  (wen),
    .inst_sram_addr (addr),
    .inst_sram_wdata(wdata),
    .inst_sram_rdata(rdata),
    .inst_sram_err  (err),
    .init_done      (init_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] ref_rdata = 32'h0;
  logic        ref_err   = 1'b0;
  bit          ref_ready = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: a byte offset from the base inside [0, 4*DEPTH) selects word offset/4.
  task automatic ref_access(input logic e, input logic [3:0] w, input logic [31:0] a,
                            input logic [31:0] d);
    longint byte_off;
    int     word;
    if (!e) return;
    byte_off = longint'(a) - longint'(BASE);
    if (byte_off >= 0 && byte_off < 4 * DEPTH) begin
      word      = int'(byte_off / 4);
      ref_rdata = ref_mem[word];
      ref_err   = 1'b0;
      for (int i = 0; i < 4; i++)
        if (w[i]) ref_mem[word][8*i +: 8] = d[8*i +: 8];
    end else begin
      ref_rdata = 32'h0;
      ref_err   = 1'b1;
    end
  endtask

  task automatic io(input string tag, input logic e, input logic [3:0] w,
                    input logic [31:0] a, input logic [31:0] d);
    en = e; wen = w; addr = a; wdata = d;
    @(posedge clk); #1;
    if (ref_ready) ref_access(e, w, a, d);
    chk({tag, "_rdata"}, rdata, ref_rdata);
    chk({tag, "_err"}, 32'(err), 32'(ref_err));
  endtask

  // Hammers a hit address with writes during CLEAR; all must be ignored.
  task automatic clear_seq(input string tag);
    for (int i = 1; i <= DEPTH; i++) begin
      en = 1'b1; wen = 4'hF; addr = BASE + 32'(4 * (i % DEPTH)); wdata = $urandom;
      @(posedge clk); #1;
      chk({tag, "_done"}, 32'(init_done), 32'(i == DEPTH));
      chk({tag, "_rdata"}, rdata, 32'h0);
    end
    foreach (ref_mem[k]) ref_mem[k] = 32'h0;
    ref_rdata = 32'h0;
    ref_err   = 1'b0;
    ref_ready = 1'b1;
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      io(tag, 1'b1, 4'h0, BASE + 32'(4 * i), $urandom);
      chk({tag, "_zero"}, rdata, 32'h0);
    end
  endtask

  initial begin
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_done", 32'(init_done), 32'h0);
    resetn = 1'b1;
    clear_seq("clr");
    read_all_zero("post_clr");

    io("wr_full", 1'b1, 4'hF, BASE + 32'h8, 32'hDEADBEEF);
    io("rd_full", 1'b1, 4'h0, BASE + 32'h8, 32'h0);
    chk("wr_rd_lit", rdata, 32'hDEADBEEF);
    io("wr_lane1", 1'b1, 4'b0010, BASE + 32'h8, 32'h0000_5500);
    io("rd_lane1", 1'b1, 4'h0, BASE + 32'h8, 32'h0);
    chk("lane_lit", rdata, 32'hDEAD55EF);

    io("wr_old", 1'b1, 4'hF, BASE, 32'h11111111);
    io("rd_first", 1'b1, 4'hF, BASE, 32'h22222222);
    chk("rd_first_lit", rdata, 32'h11111111);
    for (int i = 0; i < 3; i++) begin
      io("hold", 1'b0, 4'(i + 1), BASE + 32'(4 * i), $urandom);
      chk("hold_lit", rdata, 32'h11111111);
    end
    io("rd_new", 1'b1, 4'h0, BASE, 32'h0);
    chk("rd_new_lit", rdata, 32'h22222222);

    io("wr_last", 1'b1, 4'hF, BASE + 32'h3C, 32'hCAFE0001);
    io("rd_last", 1'b1, 4'h0, BASE + 32'h3C, 32'h0);
    chk("last_hit_lit", rdata, 32'hCAFE0001);
    io("miss_hi", 1'b1, 4'hF, BASE + 32'h40, 32'hFFFFFFFF);
    chk("miss_hi_err", 32'(err), 32'h1);
    chk("miss_hi_rdata", rdata, 32'h0);
    io("miss_lo", 1'b1, 4'h0, BASE - 32'h4, 32'h0);
    chk("miss_lo_err", 32'(err), 32'h1);
    io("hit_after", 1'b1, 4'h0, BASE, 32'h0);
    chk("word0_kept", rdata, 32'h22222222);
    chk("err_cleared", 32'(err), 32'h0);

    io("wr_w1", 1'b1, 4'hF, BASE + 32'h4, 32'hA5A50004);
    io("misalign", 1'b1, 4'h0, BASE + 32'h6, 32'h0);
    chk("misalign_lit", rdata, 32'hA5A50004);

    for (int n = 0; n < 400; n++) begin
      io("rand", ($urandom_range(0, 3) != 0), 4'($urandom),
         BASE - 32'd16 + 32'(4 * $urandom_range(0, DEPTH + 7)) + 32'($urandom_range(0, 3)),
         $urandom);
    end

    io("pre_rst_wr", 1'b1, 4'hF, BASE + 32'h8, 32'hDEADBEEF);
    io("pre_rst_rd", 1'b1, 4'h0, BASE + 32'h8, 32'h0);
    chk("pre_rst_lit", rdata, 32'hDEADBEEF);
    #3;
    resetn = 1'b0;
    #1;
    chk("async_rdata", rdata, 32'h0);
    chk("async_err", 32'(err), 32'h0);
    chk("async_done", 32'(init_done), 32'h0);
    ref_ready = 1'b0;
    #2;
    resetn = 1'b1;
    for (int i = 0; i < 7; i++) begin
      en = 1'b1; wen = 4'hF; addr = BASE + 32'(4 * i); wdata = $urandom;
      @(posedge clk); #1;
    end
    chk("mid_clr_done", 32'(init_done), 32'h0);
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_clr_rst_done", 32'(init_done), 32'h0);
    #1;
    resetn = 1'b1;
    clear_seq("clr2");
    read_all_zero("post_clr2");

    for (int n = 0; n < 100; n++) begin
      io("rand2", ($urandom_range(0, 3) != 0), 4'($urandom),
         BASE - 32'd16 + 32'(4 * $urandom_range(0, DEPTH + 7)) + 32'($urandom_range(0, 3)),
         $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
